motor_move_ctrl: RTL and testbench

- Sits downstream of the five-key input stage.
- Takes a committed move command: one-hot motor select plus a three-digit BCD target position, 0–999.
- Drives step/direction outputs for six stepper motors until the selected motor reaches the target.
- Keeps a 10-bit absolute position per motor and reports completion, errors and the current position for display.

---
 rtl/motor_move_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_motor_move_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_move_ctrl.sv
// Six-axis stepper move controller: validates a one-hot/BCD move command and steps the selected motor to its target.
// Optional abort input enabled by defining MOTOR_ABORT_EN.
`timescale 1ns/1ps
module motor_move_ctrl #(
    parameter int unsigned STEP_DIV = 50000
) (
    input  logic       sysclk,
    input  logic       INIT_n,
    input  logic       Start,
    input  logic [3:0] TValue0,
    input  logic [3:0] TValue1,
    input  logic [3:0] TValue2,
    input  logic [5:0] Motor,
`ifdef MOTOR_ABORT_EN
    input  logic       Abort,
`endif
    output logic [5:0] Step,
    output logic [5:0] Dir,
    output logic       Busy,
    output logic       Done,
    output logic       Err,
    output logic [9:0] Pos
);

    localparam int unsigned NMOT  = 6;
    localparam int unsigned CNT_W = 20;
    localparam int unsigned POS_W = 10;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_STEP_HI = 3'd3;
    localparam logic [2:0] S_STEP_LO = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [11:0]      digits_q, digits_d;
    logic [POS_W-1:0] target_q, target_d;
    logic [POS_W-1:0] pos_q [NMOT];
    logic [POS_W-1:0] pos_d [NMOT];
    logic [NMOT-1:0]  dir_q, dir_d;
    logic             err_d;

    logic [NMOT-1:0]  step_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [POS_W-1:0] pos_out_q;

    logic             abort_c;
    logic             cmd_ok_c;
    logic [2:0]       motor_idx_c;
    logic [POS_W-1:0] bcd_c;
    logic [POS_W-1:0] pos_cur_c;
    logic [POS_W-1:0] pos_next_c;

`ifdef MOTOR_ABORT_EN
    assign abort_c = Abort;
`else
    assign abort_c = 1'b0;
`endif

    // Command validation: exactly one motor bit and three legal BCD digits.
    assign cmd_ok_c = (Motor != '0) && ((Motor & (Motor - 6'd1)) == '0)
                      && (TValue0 <= 4'd9) && (TValue1 <= 4'd9) && (TValue2 <= 4'd9);

    always_comb begin
        motor_idx_c = '0;
        for (int i = 0; i < int'(NMOT); i++) begin
            if (Motor[i]) motor_idx_c = 3'(i);
        end
    end

    assign bcd_c = POS_W'(digits_q[11:8]) * POS_W'(100)
                 + POS_W'(digits_q[7:4])  * POS_W'(10)
                 + POS_W'(digits_q[3:0]);

    assign pos_cur_c  = pos_q[sel_q];
    assign pos_next_c = dir_q[sel_q] ? (pos_cur_c + POS_W'(1)) : (pos_cur_c - POS_W'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        digits_d = digits_q;
        target_d = target_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (cmd_ok_c) begin
                        sel_d    = motor_idx_c;
                        digits_d = {TValue0, TValue1, TValue2};
                        state_d  = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            // Direction is resolved on entry to CHECK so it leads the first Step edge by a full cycle;
            // every step moves toward the target, so it never needs to flip mid-move.
            S_LOAD: begin
                target_d = bcd_c;
                cnt_d    = '0;
                state_d  = S_CHECK;
                if (bcd_c != pos_cur_c) dir_d[sel_q] = (bcd_c > pos_cur_c);
            end
            S_CHECK: begin
                cnt_d   = '0;
                state_d = (target_q == pos_cur_c) ? S_DONE : S_STEP_HI;
            end
            S_STEP_HI: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_STEP_LO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STEP_LO: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d         = '0;
                    pos_d[sel_q]  = pos_next_c;
                    state_d       = S_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort discards any step still in flight; only completed steps are kept.
        if (abort_c && (state_q inside {S_LOAD, S_CHECK, S_STEP_HI, S_STEP_LO})) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pos_d   = pos_q;
            dir_d   = dir_q;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!INIT_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            digits_q  <= '0;
            target_q  <= '0;
            dir_q     <= '0;
            for (int i = 0; i < int'(NMOT); i++) pos_q[i] <= '0;
            step_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            pos_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            digits_q  <= digits_d;
            target_q  <= target_d;
            dir_q     <= dir_d;
            pos_q     <= pos_d;
            // Outputs are decoded from the next state so they line up with the state they describe.
            step_q    <= (state_d == S_STEP_HI) ? (6'd1 << sel_d) : '0;
            busy_q    <= (state_d inside {S_LOAD, S_CHECK, S_STEP_HI, S_STEP_LO});
            done_q    <= (state_d == S_DONE);
            err_q     <= err_d;
            pos_out_q <= pos_q[sel_q];
        end
    end

    assign Step = step_q;
    assign Dir  = dir_q;
    assign Busy = busy_q;
    assign Done = done_q;
    assign Err  = err_q;
    assign Pos  = pos_out_q;

endmodule

// File: tb/tb_motor_move_ctrl.sv
// Bench for motor_move_ctrl: directed commands checked every cycle against a timeline model of each move.
`timescale 1ns/1ps
module tb_motor_move_ctrl;

    localparam int unsigned D   = 2;
    localparam int          PER = 2 * D + 1;

    logic       sysclk = 1'b0;
    logic       INIT_n;
    logic       Start;
    logic [3:0] TValue0, TValue1, TValue2;
    logic [5:0] Motor;
    logic [5:0] Step, Dir;
    logic       Busy, Done, Err;
    logic [9:0] Pos;
`ifdef MOTOR_ABORT_EN
    logic       Abort;
`endif

    motor_move_ctrl #(.STEP_DIV(D)) dut (
        .sysclk (sysclk),
        .INIT_n (INIT_n),
        .Start  (Start),
        .TValue0(TValue0),
        .TValue1(TValue1),
        .TValue2(TValue2),
        .Motor  (Motor),
`ifdef MOTOR_ABORT_EN
        .Abort  (Abort),
`endif
        .Step   (Step),
        .Dir    (Dir),
        .Busy   (Busy),
        .Done   (Done),
        .Err    (Err),
        .Pos    (Pos)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model of the move in flight: kind 0 idle, 1 move, 2 rejected command.
    int         m_kind = 0;
    int         m_t0   = 0;
    int         m_n, m_T, m_sel, m_target, m_start_pos;
    int         m_abort_at = -1;
    int         m_disp = 0;
    logic       m_up;
    int         exp_pos [6];
    logic [5:0] exp_dir = '0;

    int   last_done_c, rise_cnt, err_cnt;
    logic prev_s2 = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        int c, done_steps, e_pos;
        logic [5:0] e_step;
        logic e_busy, e_done, e_err, pos_ok;
        c      = cyc - m_t0;
        e_step = '0;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_err  = 1'b0;
        pos_ok = 1'b1;
        e_pos  = exp_pos[m_disp];
        if (m_kind == 2) begin
            if (c == 1) e_err = 1'b1;
            if (c >= 1) m_kind = 0;
        end else if (m_kind == 1) begin
            if (m_abort_at >= 0 && c == m_abort_at + 1) begin
                done_steps = (m_abort_at >= 2) ? (m_abort_at - 2) / PER : 0;
                if (done_steps > m_n) done_steps = m_n;
                exp_pos[m_sel] = m_up ? m_start_pos + done_steps : m_start_pos - done_steps;
                m_disp = m_sel;
                m_kind = 0;
                e_err  = 1'b1;
                e_pos  = exp_pos[m_sel];
            end else if (c == m_T + 1) begin
                exp_pos[m_sel] = m_target;
                m_disp = m_sel;
                m_kind = 0;
                e_pos  = m_target;
            end else begin
                if (c == 2 && m_n > 0) exp_dir[m_sel] = m_up;
                e_busy = (c >= 1 && c < m_T);
                e_done = (c == m_T);
                if (c >= 3 && c < m_T && ((c - 3) % PER) < int'(D)) e_step[m_sel] = 1'b1;
                pos_ok = (c == m_T);
                e_pos  = m_target;
            end
        end
        chk("step", int'(Step), int'(e_step));
        chk("dir",  int'(Dir),  int'(exp_dir));
        chk("busy", int'(Busy), int'(e_busy));
        chk("done", int'(Done), int'(e_done));
        chk("err",  int'(Err),  int'(e_err));
        if (pos_ok) chk("pos", int'(Pos), e_pos);
        if (Done) last_done_c = c;
        if (Err) err_cnt++;
        if (Step[2] && !prev_s2) rise_cnt++;
        prev_s2 = Step[2];
    endtask

    task automatic tick();
        @(posedge sysclk);
        cyc++;
        @(negedge sysclk);
        check_outputs();
    endtask

    task automatic start_cmd(input logic [5:0] mot, input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2);
        int ones, idx;
        ones = 0;
        idx  = 0;
        for (int i = 0; i < 6; i++) begin
            if (mot[i]) begin
                ones++;
                idx = i;
            end
        end
        Motor   = mot;
        TValue0 = d0;
        TValue1 = d1;
        TValue2 = d2;
        Start   = 1'b1;
        m_t0       = cyc;
        m_abort_at = -1;
        last_done_c = -1;
        if (ones == 1 && d0 <= 4'd9 && d1 <= 4'd9 && d2 <= 4'd9) begin
            m_sel       = idx;
            m_target    = int'(d0) * 100 + int'(d1) * 10 + int'(d2);
            m_start_pos = exp_pos[idx];
            m_up        = (m_target > m_start_pos);
            m_n         = m_up ? m_target - m_start_pos : m_start_pos - m_target;
            m_T         = 3 + m_n * PER;
            m_kind      = 1;
        end else begin
            m_kind = 2;
        end
        tick();
        Start = 1'b0;
    endtask

    task automatic run_to(input int c_end);
        while (cyc - m_t0 < c_end) tick();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) exp_pos[i] = 0;
        exp_dir = '0;
        m_kind  = 0;
        m_disp  = 0;
    endtask

    initial begin
        INIT_n = 1'b0;
        Start  = 1'b0;
        Motor  = '0;
        TValue0 = '0;
        TValue1 = '0;
        TValue2 = '0;
`ifdef MOTOR_ABORT_EN
        Abort = 1'b0;
`endif
        model_reset();
        repeat (3) tick();
        chk("reset_step", int'(Step), 0);
        chk("reset_pos", int'(Pos), 0);
        INIT_n = 1'b1;
        tick();

        // Move motor 3 from 0 to 12.
        rise_cnt = 0;
        start_cmd(6'b000100, 4'd0, 4'd1, 4'd2);
        run_to(65);
        chk("A_done_cycle", last_done_c, 63);
        chk("A_pulses", rise_cnt, 12);
        chk("A_pos", int'(Pos), 12);
        chk("A_dir2", int'(Dir[2]), 1);

        // Back down to 5.
        rise_cnt = 0;
        start_cmd(6'b000100, 4'd0, 4'd0, 4'd5);
        run_to(40);
        chk("B_done_cycle", last_done_c, 38);
        chk("B_pulses", rise_cnt, 7);
        chk("B_pos", int'(Pos), 5);
        chk("B_dir2", int'(Dir[2]), 0);

        // Motor 1 already at target 0: zero-step move.
        start_cmd(6'b000001, 4'd0, 4'd0, 4'd0);
        run_to(5);
        chk("C_done_cycle", last_done_c, 3);
        chk("C_pos", int'(Pos), 0);

        // Rejected commands.
        err_cnt = 0;
        start_cmd(6'b000000, 4'd0, 4'd0, 4'd1);
        run_to(4);
        start_cmd(6'b000011, 4'd0, 4'd0, 4'd1);
        run_to(4);
        start_cmd(6'b000100, 4'd0, 4'hA, 4'd1);
        run_to(4);
        chk("rej_err_pulses", err_cnt, 3);

        // Start while busy is ignored.
        start_cmd(6'b000010, 4'd0, 4'd0, 4'd3);
        run_to(5);
        Motor   = 6'b000001;
        TValue0 = 4'd9;
        TValue1 = 4'd9;
        TValue2 = 4'd9;
        Start   = 1'b1;
        run_to(8);
        Start = 1'b0;
        run_to(20);
        chk("busy_start_done", last_done_c, 18);
        chk("busy_start_pos", int'(Pos), 3);

`ifdef MOTOR_ABORT_EN
        start_cmd(6'b100000, 4'd0, 4'd1, 4'd0);
        m_abort_at = 17;
        run_to(17);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        run_to(22);
        chk("abort_no_done", last_done_c, -1);
        chk("abort_pos", int'(Pos), 3);
`endif

        // Reset during STEP_HI of motor 3 (5 -> 9).
        start_cmd(6'b000100, 4'd0, 4'd0, 4'd9);
        run_to(4);
        INIT_n = 1'b0;
        model_reset();
        tick();
        chk("rst_mid_step", int'(Step), 0);
        tick();
        INIT_n = 1'b1;
        tick();
        start_cmd(6'b000100, 4'd0, 4'd0, 4'd0);
        run_to(5);
        chk("rst_m3_zero", last_done_c, 3);
        start_cmd(6'b000010, 4'd0, 4'd0, 4'd0);
        run_to(5);
        chk("rst_m2_zero", last_done_c, 3);
        chk("rst_pos", int'(Pos), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
